// File: rtl/control_fsm_if.sv
// -----------------------------------------------------------------------------
// control_fsm_if
//   Bundle between the RiSC-16 multi-cycle control unit and its datapath.
//   master : the control FSM. It observes the IR, the ALU compare result and
//            memory readiness, and it drives all datapath and memory controls.
//   slave  : the datapath/memory side. It supplies the status inputs and
//            consumes the controls.
//   Signals:
//     instruction[15:0]  IR contents (valid from DECODE onward)
//     eq                 ALU compare result (1 = operands equal)
//     mem_ready          memory finishes the current request this cycle
//     mem_req/mem_we     memory request / write (1) vs read (0)
//     mem_sel_pc         memory address source: 1 = PC, 0 = ALU result
//     WE_ir, WE_pc       IR / PC load enables
//     MUX_pc[1:0]        00 pc+1, 01 pc+1+simm7, 10 rB
//     WE_rf, MUX_rf      register-file write enable / reg_out2 source (1 = rA)
//     MUX_tgt[1:0]       write-back source: 00 mem_out, 01 alu_out, 10 pc+1
//     MUX_alu_b          ALU B input: 0 reg_out2, 1 immediate
//     alu_op[1:0]        00 add, 01 nand, 10 pass imm10<<6, 11 compare
// -----------------------------------------------------------------------------
interface control_fsm_if;
    logic [15:0] instruction;
    logic        eq;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        mem_sel_pc;
    logic        WE_ir;
    logic        WE_pc;
    logic [1:0]  MUX_pc;
    logic        WE_rf;
    logic        MUX_rf;
    logic [1:0]  MUX_tgt;
    logic        MUX_alu_b;
    logic [1:0]  alu_op;

    modport master (
        input  instruction, eq, mem_ready,
        output mem_req, mem_we, mem_sel_pc, WE_ir, WE_pc, MUX_pc,
               WE_rf, MUX_rf, MUX_tgt, MUX_alu_b, alu_op
    );

    modport slave (
        output instruction, eq, mem_ready,
        input  mem_req, mem_we, mem_sel_pc, WE_ir, WE_pc, MUX_pc,
               WE_rf, MUX_rf, MUX_tgt, MUX_alu_b, alu_op
    );
endinterface

// File: rtl/control_fsm.sv
// -----------------------------------------------------------------------------
// control_fsm
//   Multi-cycle control unit for the 16-bit RiSC-16 datapath. It sequences
//   IDLE -> FETCH -> DECODE -> EXEC -> (MEM | WB) -> FETCH from IR[15:13] and
//   decodes every datapath/memory control combinationally from the current
//   state, opcode, eq and mem_ready. JALR with a nonzero imm7 is HALT.
//   Ports:
//     clk      in   rising-edge clock
//     rst_n    in   asynchronous active-low reset
//     bus      if   control_fsm_if.master (IR/status in, controls out)
//     halted   out  1 once the core has executed HALT
//     state    out  current FSM state encoding
//     instret  out  retired-instruction count, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    control_fsm_if.master    bus,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_ADDI = 3'b001,
        OP_NAND = 3'b010,
        OP_LUI  = 3'b011,
        OP_SW   = 3'b100,
        OP_LW   = 3'b101,
        OP_BEQ  = 3'b110,
        OP_JALR = 3'b111
    } opcode_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_instret;

    state_t  w_next_state;
    logic    w_retire;
    opcode_t w_opcode;
    logic    w_is_halt;
    logic    w_unused_instr_bits;

    assign w_opcode  = opcode_t'(bus.instruction[15:13]);
    // HALT shares the JALR opcode and is told apart by a nonzero imm7 field.
    assign w_is_halt = (w_opcode == OP_JALR) && (bus.instruction[6:0] != 7'd0);
    // Register fields are consumed by the datapath, not by this unit.
    assign w_unused_instr_bits = ^bus.instruction[12:7];

    // NOTE: every signal written here gets a default first so that no path
    // through the case statements leaves it unassigned and infers a latch.
    always_comb begin
        w_next_state  = r_state;
        w_retire      = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_sel_pc = 1'b0;
        bus.WE_ir      = 1'b0;
        bus.WE_pc      = 1'b0;
        bus.MUX_pc     = 2'b00;
        bus.WE_rf      = 1'b0;
        bus.MUX_rf     = 1'b0;
        bus.MUX_tgt    = 2'b00;
        bus.MUX_alu_b  = 1'b0;
        bus.alu_op     = 2'b00;
        halted         = 1'b0;

        unique case (r_state)
            S_IDLE: w_next_state = S_FETCH;

            S_FETCH: begin
                bus.mem_req    = 1'b1;
                bus.mem_sel_pc = 1'b1;
                if (bus.mem_ready) begin
                    bus.WE_ir    = 1'b1;
                    w_next_state = S_DECODE;
                end
            end

            S_DECODE: begin
                // rA is routed to reg_out2 early for SW data and BEQ compare.
                bus.MUX_rf = (w_opcode == OP_SW) || (w_opcode == OP_BEQ);
                if (w_is_halt) begin
                    w_retire     = 1'b1;
                    w_next_state = S_HALT;
                end else begin
                    w_next_state = S_EXEC;
                end
            end

            S_EXEC, S_WB: begin
                unique case (w_opcode)
                    OP_ADD:  begin bus.alu_op = 2'b00; bus.MUX_alu_b = 1'b0; end
                    OP_ADDI: begin bus.alu_op = 2'b00; bus.MUX_alu_b = 1'b1; end
                    OP_NAND: begin bus.alu_op = 2'b01; bus.MUX_alu_b = 1'b0; end
                    OP_LUI:  begin bus.alu_op = 2'b10; bus.MUX_alu_b = 1'b1; end
                    OP_LW:   begin bus.alu_op = 2'b00; bus.MUX_alu_b = 1'b1; end
                    OP_SW: begin
                        bus.alu_op    = 2'b00;
                        bus.MUX_alu_b = 1'b1;
                        bus.MUX_rf    = 1'b1;
                    end
                    OP_BEQ: begin
                        bus.alu_op = 2'b11;
                        bus.MUX_rf = 1'b1;
                    end
                    OP_JALR: ;
                endcase

                if (r_state == S_WB) begin
                    bus.WE_rf    = 1'b1;
                    bus.MUX_tgt  = 2'b01;
                    bus.WE_pc    = 1'b1;
                    bus.MUX_pc   = 2'b00;
                    w_retire     = 1'b1;
                    w_next_state = S_FETCH;
                end else begin
                    unique case (w_opcode)
                        OP_ADD, OP_ADDI, OP_NAND, OP_LUI: w_next_state = S_WB;
                        OP_LW, OP_SW:                     w_next_state = S_MEM;
                        OP_BEQ: begin
                            bus.WE_pc    = 1'b1;
                            bus.MUX_pc   = bus.eq ? 2'b01 : 2'b00;
                            w_retire     = 1'b1;
                            w_next_state = S_FETCH;
                        end
                        OP_JALR: begin
                            // Link and jump share one edge: the PC loads the
                            // pre-write rB even when rA == rB.
                            bus.WE_rf    = 1'b1;
                            bus.MUX_tgt  = 2'b10;
                            bus.WE_pc    = 1'b1;
                            bus.MUX_pc   = 2'b10;
                            w_retire     = 1'b1;
                            w_next_state = S_FETCH;
                        end
                    endcase
                end
            end

            S_MEM: begin
                // Address path held stable for the whole request.
                bus.mem_req    = 1'b1;
                bus.mem_sel_pc = 1'b0;
                bus.alu_op     = 2'b00;
                bus.MUX_alu_b  = 1'b1;
                if (w_opcode == OP_SW) begin
                    bus.mem_we = 1'b1;
                    bus.MUX_rf = 1'b1;
                end
                if (bus.mem_ready) begin
                    bus.WE_pc    = 1'b1;
                    bus.MUX_pc   = 2'b00;
                    w_retire     = 1'b1;
                    w_next_state = S_FETCH;
                    // mem_out is only valid on the completing cycle.
                    if (w_opcode == OP_LW) begin
                        bus.WE_rf   = 1'b1;
                        bus.MUX_tgt = 2'b00;
                    end
                end
            end

            S_HALT: halted = 1'b1;

            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_instret <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_retire) begin
                r_instret <= r_instret + 1'b1;
            end
        end
    end

    assign state   = r_state;
    assign instret = r_instret;

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;

    localparam int CNT_W = 4;

    localparam logic [15:0] I_ADD  = 16'h0503;
    localparam logic [15:0] I_ADDI = 16'h2481;
    localparam logic [15:0] I_NAND = 16'h4503;
    localparam logic [15:0] I_LUI  = 16'h6400;
    localparam logic [15:0] I_SW   = 16'h8481;
    localparam logic [15:0] I_LW   = 16'hA501;
    localparam logic [15:0] I_BEQ  = 16'hC281;
    localparam logic [15:0] I_JALR = 16'hE500;
    localparam logic [15:0] I_HALT = 16'hE001;

    typedef struct packed {
        logic [2:0]       st;
        logic             req;
        logic             we;
        logic             sel;
        logic             weir;
        logic             wepc;
        logic [1:0]       mpc;
        logic             werf;
        logic             mrf;
        logic [1:0]       mtgt;
        logic             alub;
        logic [1:0]       aop;
        logic             hlt;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    control_fsm_if bus_if ();
    logic             halted;
    logic [2:0]       state;
    logic [CNT_W-1:0] instret;

    control_fsm #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus_if),
        .halted  (halted),
        .state   (state),
        .instret (instret)
    );

    exp_t sb_q[$];
    int   sb_tag[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;

    function automatic exp_t ev(
        input logic [2:0] st, input logic req, input logic we, input logic sel,
        input logic weir, input logic wepc, input logic [1:0] mpc,
        input logic werf, input logic mrf, input logic [1:0] mtgt,
        input logic alub, input logic [1:0] aop, input logic hlt,
        input logic [CNT_W-1:0] cnt);
        exp_t x;
        x = '{st, req, we, sel, weir, wepc, mpc, werf, mrf, mtgt, alub, aop, hlt, cnt};
        return x;
    endfunction

    function automatic exp_t fetch_exp(input logic rdy, input logic [CNT_W-1:0] cnt);
        return ev(3'd1, 1, 0, 1, rdy, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0, cnt);
    endfunction

    task automatic check(input exp_t act, input exp_t req, input int tag);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL ctrl step %0d: actual st=%0d bits=%h required st=%0d bits=%h",
                     tag, act.st, act, req.st, req);
        end
    endtask

    // Drive one cycle's inputs just after the edge and queue what the DUT
    // must present during that cycle.
    task automatic cyc(input logic rn, input logic [15:0] ir, input logic e,
                       input logic rdy, input exp_t x);
        @(posedge clk);
        #1;
        rst_n               = rn;
        bus_if.instruction  = ir;
        bus_if.eq           = e;
        bus_if.mem_ready    = rdy;
        sb_q.push_back(x);
        sb_tag.push_back(step_no);
        step_no++;
    endtask

    // Monitor: independent of the stimulus, compares on the falling edge.
    always @(negedge clk) begin
        exp_t act;
        exp_t req;
        int   tag;
        if (sb_q.size() > 0) begin
            req = sb_q.pop_front();
            tag = sb_tag.pop_front();
            act = '{state, bus_if.mem_req, bus_if.mem_we, bus_if.mem_sel_pc,
                    bus_if.WE_ir, bus_if.WE_pc, bus_if.MUX_pc, bus_if.WE_rf,
                    bus_if.MUX_rf, bus_if.MUX_tgt, bus_if.MUX_alu_b,
                    bus_if.alu_op, halted, instret};
            check(act, req, tag);
        end
    end

    initial begin
        bus_if.instruction = 16'h0000;
        bus_if.eq          = 1'b0;
        bus_if.mem_ready   = 1'b0;

        // Reset and the IDLE cycle after release: everything 0.
        cyc(0, I_ADD, 0, 1, ev(3'd0, 0,0,0,0,0,2'b00,0,0,2'b00,0,2'b00,0, 4'd0));
        cyc(1, I_ADD, 0, 1, ev(3'd0, 0,0,0,0,0,2'b00,0,0,2'b00,0,2'b00,0, 4'd0));

        // ADD r1,r2,r3: FETCH, DECODE, EXEC, WB.
        cyc(1, I_ADD, 0, 1, fetch_exp(1, 4'd0));
        cyc(1, I_ADD, 0, 1, ev(3'd2, 0,0,0,0,0,2'b00,0,0,2'b00,0,2'b00,0, 4'd0));
        cyc(1, I_ADD, 0, 1, ev(3'd3, 0,0,0,0,0,2'b00,0,0,2'b00,0,2'b00,0, 4'd0));
        cyc(1, I_ADD, 0, 1, ev(3'd5, 0,0,0,0,1,2'b00,1,0,2'b01,0,2'b00,0, 4'd0));

        // LW with three MEM stall cycles.
        cyc(1, I_LW, 0, 1, fetch_exp(1, 4'd1));
        cyc(1, I_LW, 0, 1, ev(3'd2, 0,0,0,0,0,2'b00,0,0,2'b00,0,2'b00,0, 4'd1));
        cyc(1, I_LW, 0, 1, ev(3'd3, 0,0,0,0,0,2'b00,0,0,2'b00,1,2'b00,0, 4'd1));
        cyc(1, I_LW, 0, 0, ev(3'd4, 1,0,0,0,0,2'b00,0,0,2'b00,1,2'b00,0, 4'd1));
        cyc(1, I_LW, 0, 0, ev(3'd4, 1,0,0,0,0,2'b00,0,0,2'b00,1,2'b00,0, 4'd1));
        cyc(1, I_LW, 0, 0, ev(3'd4, 1,0,0,0,0,2'b00,0,0,2'b00,1,2'b00,0, 4'd1));
        cyc(1, I_LW, 0, 1, ev(3'd4, 1,0,0,0,1,2'b00,1,0,2'b00,1,2'b00,0, 4'd1));

        // FETCH stall, then BEQ taken.
        cyc(1, I_BEQ, 1, 0, fetch_exp(0, 4'd2));
        cyc(1, I_BEQ, 1, 1, fetch_exp(1, 4'd2));
        cyc(1, I_BEQ, 1, 1, ev(3'd2, 0,0,0,0,0,2'b00,0,1,2'b00,0,2'b00,0, 4'd2));
        cyc(1, I_BEQ, 1, 1, ev(3'd3, 0,0,0,0,1,2'b01,0,1,2'b00,0,2'b11,0, 4'd2));

        // BEQ not taken.
        cyc(1, I_BEQ, 0, 1, fetch_exp(1, 4'd3));
        cyc(1, I_BEQ, 0, 1, ev(3'd2, 0,0,0,0,0,2'b00,0,1,2'b00,0,2'b00,0, 4'd3));
        cyc(1, I_BEQ, 0, 1, ev(3'd3, 0,0,0,0,1,2'b00,0,1,2'b00,0,2'b11,0, 4'd3));

        // JALR r1,r2.
        cyc(1, I_JALR, 0, 1, fetch_exp(1, 4'd4));
        cyc(1, I_JALR, 0, 1, ev(3'd2, 0,0,0,0,0,2'b00,0,0,2'b00,0,2'b00,0, 4'd4));
        cyc(1, I_JALR, 0, 1, ev(3'd3, 0,0,0,0,1,2'b10,1,0,2'b10,0,2'b00,0, 4'd4));

        // SW with one MEM stall.
        cyc(1, I_SW, 0, 1, fetch_exp(1, 4'd5));
        cyc(1, I_SW, 0, 1, ev(3'd2, 0,0,0,0,0,2'b00,0,1,2'b00,0,2'b00,0, 4'd5));
        cyc(1, I_SW, 0, 1, ev(3'd3, 0,0,0,0,0,2'b00,0,1,2'b00,1,2'b00,0, 4'd5));
        cyc(1, I_SW, 0, 0, ev(3'd4, 1,1,0,0,0,2'b00,0,1,2'b00,1,2'b00,0, 4'd5));
        cyc(1, I_SW, 0, 1, ev(3'd4, 1,1,0,0,1,2'b00,0,1,2'b00,1,2'b00,0, 4'd5));

        // NAND.
        cyc(1, I_NAND, 0, 1, fetch_exp(1, 4'd6));
        cyc(1, I_NAND, 0, 1, ev(3'd2, 0,0,0,0,0,2'b00,0,0,2'b00,0,2'b00,0, 4'd6));
        cyc(1, I_NAND, 0, 1, ev(3'd3, 0,0,0,0,0,2'b00,0,0,2'b00,0,2'b01,0, 4'd6));
        cyc(1, I_NAND, 0, 1, ev(3'd5, 0,0,0,0,1,2'b00,1,0,2'b01,0,2'b01,0, 4'd6));

        // LUI.
        cyc(1, I_LUI, 0, 1, fetch_exp(1, 4'd7));
        cyc(1, I_LUI, 0, 1, ev(3'd2, 0,0,0,0,0,2'b00,0,0,2'b00,0,2'b00,0, 4'd7));
        cyc(1, I_LUI, 0, 1, ev(3'd3, 0,0,0,0,0,2'b00,0,0,2'b00,1,2'b10,0, 4'd7));
        cyc(1, I_LUI, 0, 1, ev(3'd5, 0,0,0,0,1,2'b00,1,0,2'b01,1,2'b10,0, 4'd7));

        // ADDI.
        cyc(1, I_ADDI, 0, 1, fetch_exp(1, 4'd8));
        cyc(1, I_ADDI, 0, 1, ev(3'd2, 0,0,0,0,0,2'b00,0,0,2'b00,0,2'b00,0, 4'd8));
        cyc(1, I_ADDI, 0, 1, ev(3'd3, 0,0,0,0,0,2'b00,0,0,2'b00,1,2'b00,0, 4'd8));
        cyc(1, I_ADDI, 0, 1, ev(3'd5, 0,0,0,0,1,2'b00,1,0,2'b01,1,2'b00,0, 4'd8));

        // Seven ADDs take instret from 9 through 15 and wrap it to 0.
        for (int i = 0; i < 7; i++) begin
            logic [CNT_W-1:0] c;
            c = CNT_W'(9 + i);
            cyc(1, I_ADD, 0, 1, fetch_exp(1, c));
            cyc(1, I_ADD, 0, 1, ev(3'd2, 0,0,0,0,0,2'b00,0,0,2'b00,0,2'b00,0, c));
            cyc(1, I_ADD, 0, 1, ev(3'd3, 0,0,0,0,0,2'b00,0,0,2'b00,0,2'b00,0, c));
            cyc(1, I_ADD, 0, 1, ev(3'd5, 0,0,0,0,1,2'b00,1,0,2'b01,0,2'b00,0, c));
        end

        // SW retires (0 -> 1), then a second SW is reset mid-MEM.
        cyc(1, I_SW, 0, 1, fetch_exp(1, 4'd0));
        cyc(1, I_SW, 0, 1, ev(3'd2, 0,0,0,0,0,2'b00,0,1,2'b00,0,2'b00,0, 4'd0));
        cyc(1, I_SW, 0, 1, ev(3'd3, 0,0,0,0,0,2'b00,0,1,2'b00,1,2'b00,0, 4'd0));
        cyc(1, I_SW, 0, 1, ev(3'd4, 1,1,0,0,1,2'b00,0,1,2'b00,1,2'b00,0, 4'd0));
        cyc(1, I_SW, 0, 1, fetch_exp(1, 4'd1));
        cyc(1, I_SW, 0, 1, ev(3'd2, 0,0,0,0,0,2'b00,0,1,2'b00,0,2'b00,0, 4'd1));
        cyc(1, I_SW, 0, 1, ev(3'd3, 0,0,0,0,0,2'b00,0,1,2'b00,1,2'b00,0, 4'd1));
        cyc(1, I_SW, 0, 0, ev(3'd4, 1,1,0,0,0,2'b00,0,1,2'b00,1,2'b00,0, 4'd1));
        cyc(0, I_SW, 0, 0, ev(3'd0, 0,0,0,0,0,2'b00,0,0,2'b00,0,2'b00,0, 4'd0));
        cyc(1, I_SW, 0, 1, ev(3'd0, 0,0,0,0,0,2'b00,0,0,2'b00,0,2'b00,0, 4'd0));

        // HALT: retires in DECODE, then stays put with mem_ready toggling.
        cyc(1, I_HALT, 0, 1, fetch_exp(1, 4'd0));
        cyc(1, I_HALT, 0, 1, ev(3'd2, 0,0,0,0,0,2'b00,0,0,2'b00,0,2'b00,0, 4'd0));
        for (int i = 0; i < 20; i++) begin
            cyc(1, I_HALT, 1'(i), 1'(i), ev(3'd6, 0,0,0,0,0,2'b00,0,0,2'b00,0,2'b00,1, 4'd1));
        end

        // Let the monitor drain the last entry.
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: actual pending=%0d required pending=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
